// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Holds the FSM state enum, parity mode codes and data_len clamp limits.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK
  } state_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [3:0] LEN_MIN = 4'd5;

  function automatic logic [3:0] clamp_len(
    input logic [3:0] len,
    input logic [3:0] len_max
  );
    if (len < LEN_MIN) return LEN_MIN;
    if (len > len_max) return len_max;
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with full/empty/level flags and sticky overflow.
// Ports: clk, arst_n/srst resets, wr_en/wr_data push, rd_en pop with
// rd_data showing the head, clr_ovf, full, empty, level, overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          srst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    push     = wr_en & ~full;
    pop      = rd_en & ~empty;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = ovf_q;
    // A dropped write beats a same-cycle clear.
    if (wr_en && full) ovf_d = 1'b1;
    else if (clr_ovf)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed frame FSM with 5..DATA_W data bits, parity,
// one/two stop bits and break. Ports: clk, reset_n, xmit_pulse bit strobe,
// wr_en/wr_data, frame config inputs, send_break, clr_ovf; outputs tx,
// FIFO flags/level, overflow, busy and the one-clock tx_done pulse.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_RESET = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        xmit_pulse,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [3:0]                  data_len,
  input  logic [2:0]                  parity_mode,
  input  logic                        stop2,
  input  logic                        send_break,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx_done
);

  localparam logic [3:0] LEN_MAX = 4'(DATA_W);

  logic arst_n, srst;
  assign arst_n = (SYNC_RESET != 0) ? 1'b1 : reset_n;
  assign srst   = (SYNC_RESET != 0) & ~reset_n;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic              pen_q, pen_d;
  logic              pbit_q, pbit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              pop, load, frame_end;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        len_c;
  logic              pen_c, pbit_c, xor_c;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .srst     (srst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .clr_ovf  (clr_ovf),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (overflow)
  );

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = (state_q != S_IDLE);

  // Frame config and parity of the FIFO head, captured on each pop.
  always_comb begin
    len_c  = clamp_len(data_len, LEN_MAX);
    xor_c  = 1'b0;
    pen_c  = 1'b0;
    pbit_c = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len_c)) xor_c ^= rd_data[i];
    end
    unique case (parity_mode)
      PAR_EVEN:  begin pen_c = 1'b1; pbit_c = xor_c;  end
      PAR_ODD:   begin pen_c = 1'b1; pbit_c = ~xor_c; end
      PAR_MARK:  begin pen_c = 1'b1; pbit_c = 1'b1;   end
      PAR_SPACE: begin pen_c = 1'b1; pbit_c = 1'b0;   end
      default:   begin pen_c = 1'b0; pbit_c = 1'b0;   end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pen_d     = pen_q;
    pbit_d    = pbit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (send_break) begin
          state_d = S_BREAK;
        end else if (!fifo_empty) begin
          load    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xmit_pulse) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (xmit_pulse) begin
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xmit_pulse) begin
          if (cnt_q == len_q - 4'd1) begin
            if (pen_q) begin
              tx_d    = pbit_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP1;
            end
          end else begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (xmit_pulse) begin
          tx_d    = 1'b1;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (xmit_pulse) begin
          if (stop2_q) state_d = S_STOP2;
          else         frame_end = 1'b1;
        end
      end
      S_STOP2: begin
        if (xmit_pulse) frame_end = 1'b1;
      end
      S_BREAK: begin
        if (xmit_pulse) begin
          if (send_break) begin
            tx_d = 1'b0;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Chain straight into the next start bit when more data is queued.
    if (frame_end) begin
      done_d = 1'b1;
      if (!fifo_empty && !send_break) begin
        load    = 1'b1;
        tx_d    = 1'b0;
        state_d = S_START;
      end else begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (load) begin
      pop     = 1'b1;
      sh_d    = rd_data;
      len_d   = len_c;
      pen_d   = pen_c;
      pbit_d  = pbit_c;
      stop2_d = stop2;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_MAX;
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else if (srst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_MAX;
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      pbit_q  <= pbit_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: directed scenarios plus random
// frames, with the tx bit stream compared against a frame-level model.
module tb_uart_tx_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          xmit_pulse = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    data_len = 4'd8;
  logic [2:0]    parity_mode = 3'd0;
  logic          stop2 = 1'b0;
  logic          send_break = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          tx, fifo_full, fifo_empty;
  logic          overflow, busy, tx_done;
  logic [LW-1:0] fifo_level;

  uart_tx_param #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .SYNC_RESET (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .xmit_pulse  (xmit_pulse),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .data_len    (data_len),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .send_break  (send_break),
    .clr_ovf     (clr_ovf),
    .tx          (tx),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  bit pulse_en = 1'b0;
  int ph = 0;

  // One xmit_pulse every fourth clock while enabled.
  initial begin : pulse_gen
    forever begin
      @(posedge clk);
      #1;
      if (pulse_en) begin
        ph++;
        xmit_pulse = (ph % 4 == 0);
      end else begin
        ph = 0;
        xmit_pulse = 1'b0;
      end
    end
  end

  bit txq[$];
  bit expq[$];
  int lvlq[$];
  int pulse_cnt = 0;
  int done_cnt  = 0;

  // Record tx after every bit-time edge, and the level at each tx_done.
  initial begin : monitor
    bit p;
    forever begin
      @(posedge clk);
      p = xmit_pulse;
      #2;
      if (p) begin
        txq.push_back(tx);
        pulse_cnt++;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        lvlq.push_back(int'(fifo_level));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Expected bit times of one frame, from the framing rules.
  function automatic void model_frame(input logic [DW-1:0] d,
                                      input int raw_len,
                                      input int pm,
                                      input bit s2);
    int len;
    int ones;
    len  = raw_len < 5 ? 5 : (raw_len > DW ? DW : raw_len);
    ones = 0;
    expq.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      expq.push_back(d[i]);
      ones += int'(d[i]);
    end
    case (pm)
      1: expq.push_back(bit'(ones % 2));
      2: expq.push_back(bit'((ones + 1) % 2));
      3: expq.push_back(1'b1);
      4: expq.push_back(1'b0);
      default: ;
    endcase
    expq.push_back(1'b1);
    if (s2) expq.push_back(1'b1);
  endfunction

  task automatic clear_logs();
    txq.delete();
    expq.delete();
    lvlq.delete();
    done_cnt = 0;
  endtask

  task automatic set_cfg(input int len, input int pm, input bit s2);
    data_len    = 4'(len);
    parity_mode = 3'(pm);
    stop2       = s2;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    model_frame(d, int'(data_len), int'(parity_mode), stop2);
    write_word(d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) tick();
    while (!(busy === 1'b0 && fifo_empty === 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_idle_wait"}, 32'(n < 3000), 32'd1);
    repeat (8) tick();
  endtask

  task automatic wait_pulses(input int k);
    int t;
    int n;
    t = pulse_cnt + k;
    n = 0;
    while (pulse_cnt < t && n < 500) begin
      tick();
      n++;
    end
    chk("pulse_wait", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("busy_wait", 32'(n < 200), 32'd1);
  endtask

  // Skip idle marks, then the stream must equal the model, then idle.
  task automatic chk_stream(input string tag);
    int j;
    int mism;
    j    = 0;
    mism = 0;
    while (j < txq.size() && txq[j] == 1'b1) j++;
    foreach (expq[i]) begin
      if (j >= txq.size())          mism++;
      else if (txq[j] !== expq[i])  mism++;
      j++;
    end
    while (j < txq.size()) begin
      if (txq[j] !== 1'b1) mism++;
      j++;
    end
    chk({tag, "_stream_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin : main
    int n;
    int rem;
    int p0;
    logic [DW-1:0] d;

    reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    reset_n = 1'b1;
    tick();
    pulse_en = 1'b1;
    repeat (8) tick();

    // 8N1
    clear_logs();
    set_cfg(8, 0, 0);
    send(8'hA5);
    wait_idle("8n1");
    chk_stream("8n1");
    chk("8n1_done", 32'(done_cnt), 32'd1);
    chk("8n1_busy", 32'(busy), 32'd0);

    // 7E2
    clear_logs();
    set_cfg(7, 1, 1);
    send(8'h41);
    wait_idle("7e2");
    chk_stream("7e2");
    chk("7e2_done", 32'(done_cnt), 32'd1);

    // 5O1
    clear_logs();
    set_cfg(5, 2, 0);
    send(8'h1F);
    wait_idle("5o1");
    chk_stream("5o1");

    // Back-to-back frames with level tracking at each frame end
    clear_logs();
    set_cfg(8, 1, 0);
    n = 3;
    for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
    wait_idle("b2b");
    chk_stream("b2b");
    chk("b2b_done", 32'(done_cnt), 32'(n));
    rem = n - 1;
    for (int i = 0; i < n; i++) begin
      if (rem > 0) rem--;
      chk("b2b_level", (i < lvlq.size()) ? 32'(lvlq[i]) : 32'hFFFF,
          32'(rem));
    end

    // Overflow with no bit-time pulses
    pulse_en = 1'b0;
    repeat (4) tick();
    clear_logs();
    set_cfg(6, 2, 1);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 5) send(d);
      else       write_word(d);
    end
    repeat (2) tick();
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    clr_ovf = 1'b1;
    tick();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_level_hold", 32'(fifo_level), 32'(DEPTH));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    pulse_en = 1'b1;
    wait_idle("ovf");
    chk_stream("ovf");
    chk("ovf_done", 32'(done_cnt), 32'd5);

    // Random configurations, including out-of-range len and parity codes
    for (int b = 0; b < 6; b++) begin
      clear_logs();
      set_cfg($urandom_range(0, 15), $urandom_range(0, 7),
              1'($urandom_range(0, 1)));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
      wait_idle("rnd");
      chk_stream("rnd");
      chk("rnd_done", 32'(done_cnt), 32'(n));
    end

    // Break mid-frame, held for three bit times, then the queued word
    clear_logs();
    set_cfg(8, 1, 0);
    send(8'($urandom_range(0, 255)));
    wait_busy();
    wait_pulses(4);
    d = 8'($urandom_range(0, 255));
    write_word(d);
    send_break = 1'b1;
    n = 0;
    while (done_cnt < 1 && n < 500) begin
      tick();
      n++;
    end
    chk("brk_frame_end_wait", 32'(n < 500), 32'd1);
    p0 = pulse_cnt;
    wait_pulses(3);
    chk("brk_pulses_held", 32'(pulse_cnt - p0), 32'd3);
    send_break = 1'b0;
    expq.push_back(1'b1);
    repeat (3) expq.push_back(1'b0);
    expq.push_back(1'b1);
    model_frame(d, int'(data_len), int'(parity_mode), stop2);
    wait_idle("brk");
    chk_stream("brk");
    chk("brk_done", 32'(done_cnt), 32'd3);

    // Asynchronous reset while a zero data bit is on the line
    clear_logs();
    set_cfg(8, 0, 0);
    write_word(8'h00);
    write_word(8'($urandom_range(0, 255)));
    wait_busy();
    wait_pulses(4);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    chk("pre_rst_empty", 32'(fifo_empty), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_done", 32'(tx_done), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
